// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD17 read-command controller.
//   - state_t      : controller FSM states
//   - FRAME_LEN    : command/response frame length in bits
//   - R1_*         : bit positions of the R1 response fields
//   - CRC7_POLY    : CRC7 polynomial x^7+x^3+1 (feedback taps)
//   - DEFAULT_STATUS_ERR_MASK / CMD17_INDEX : default parameter values
package sd_pkg;

  localparam int FRAME_LEN = 48;

  localparam int R1_TX_BIT   = 46;
  localparam int R1_IDX_MSB  = 45;
  localparam int R1_IDX_LSB  = 40;
  localparam int R1_ARG_MSB  = 39;
  localparam int R1_ARG_LSB  = 8;
  localparam int R1_CRC_MSB  = 7;
  localparam int R1_CRC_LSB  = 1;
  localparam int R1_END_BIT  = 0;

  localparam logic [6:0]  CRC7_POLY               = 7'h09;
  localparam logic [31:0] DEFAULT_STATUS_ERR_MASK = 32'hFFF80000;
  localparam logic [5:0]  CMD17_INDEX             = 6'd17;

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_RESP, RECV, CHECK, DATA, NCC, FINISH
  } state_t;

  // One serial CRC7 step: shift left, fold in the feedback bit.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker (x^7+x^3+1, init 0), MSB-first input.
//   CLK, RST : clock, async active-high reset
//   CLR      : restart the CRC from zero
//   EN       : absorb BIT_IN this cycle (with CLR, BIT_IN becomes the first bit)
//   BIT_IN   : serial data bit
//   CRC      : current CRC register
module sd_crc7
  import sd_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       EN,
  input  logic       BIT_IN,
  output logic [6:0] CRC
);

  logic [6:0] base;

  // CLR together with EN starts a new CRC that already includes BIT_IN,
  // which lets the response start bit be both the restart and the first bit.
  assign base = CLR ? 7'h00 : CRC;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     CRC <= 7'h00;
    else if (EN) CRC <= crc7_step(base, BIT_IN);
    else if (CLR) CRC <= 7'h00;
  end

endmodule

// File: rtl/sd_read_cmd.sv
// CMD17 (READ_SINGLE_BLOCK) controller in front of the 4-bit SD data reader.
// Serialises the command frame, receives/checks the R1 response, enables the
// data reader, enforces NCC idle clocks and reports one result with DONE.
//   CLK, RST          : SD-domain clock, async active-high reset
//   START, ADDR       : request pulse and block address (sampled in IDLE)
//   CMD_OUT, CMD_OE   : command pad data / output enable
//   CMD_IN            : synchronised command pad input
//   RD_ENA            : data reader enable
//   RD_COMPLT, RD_NORESP : data reader completion / no-response
//   RESP              : card status of last R1 response
//   BUSY, DONE        : transaction in progress / end-of-transaction pulse
//   CRCERROR, NORESPERROR, STATUSERROR : result flags, held until next START
module sd_read_cmd
  import sd_pkg::*;
#(
  parameter logic [5:0]  CMD_INDEX       = CMD17_INDEX,
  parameter int          NCR_MAX         = 64,
  parameter int          NCC_CLKS        = 8,
  parameter logic [31:0] STATUS_ERR_MASK = DEFAULT_STATUS_ERR_MASK
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] ADDR,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  input  logic        CMD_IN,
  output logic        RD_ENA,
  input  logic        RD_COMPLT,
  input  logic        RD_NORESP,
  output logic [31:0] RESP,
  output logic        BUSY,
  output logic        DONE,
  output logic        CRCERROR,
  output logic        NORESPERROR,
  output logic        STATUSERROR
);

  state_t                 state, state_nx;
  logic [7:0]             cnt, cnt_nx;
  logic [FRAME_LEN-1:0]   sh, sh_nx;
  logic [31:0]            resp_nx;
  logic                   crc_err_nx, noresp_err_nx, stat_err_nx;
  logic                   crc_clr, crc_en, crc_bit;
  logic [6:0]             crc;
  logic [2:0]             crc_idx;
  logic                   bad_frame, bad_status;

  sd_crc7 u_crc7 (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (crc_clr),
    .EN     (crc_en),
    .BIT_IN (crc_bit),
    .CRC    (crc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      RESP        <= '0;
      CRCERROR    <= 1'b0;
      NORESPERROR <= 1'b0;
      STATUSERROR <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sh          <= sh_nx;
      RESP        <= resp_nx;
      CRCERROR    <= crc_err_nx;
      NORESPERROR <= noresp_err_nx;
      STATUSERROR <= stat_err_nx;
    end
  end

  // Frame bits 7..1 come straight out of the held CRC register: the CRC
  // stops absorbing at bit 8, so bit n maps to crc[n-1].
  assign crc_idx = cnt[2:0] - 3'd1;

  assign bad_frame  = sh[R1_TX_BIT] ||
                      (sh[R1_IDX_MSB:R1_IDX_LSB] != CMD_INDEX) ||
                      (sh[R1_CRC_MSB:R1_CRC_LSB] != crc) ||
                      !sh[R1_END_BIT];
  assign bad_status = |(sh[R1_ARG_MSB:R1_ARG_LSB] & STATUS_ERR_MASK);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    sh_nx         = sh;
    resp_nx       = RESP;
    crc_err_nx    = CRCERROR;
    noresp_err_nx = NORESPERROR;
    stat_err_nx   = STATUSERROR;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    crc_bit       = CMD_IN;
    CMD_OE        = 1'b0;
    CMD_OUT       = 1'b1;
    RD_ENA        = 1'b0;
    DONE          = 1'b0;
    BUSY          = (state != IDLE);

    unique case (state)
      IDLE: begin
        if (START) begin
          sh_nx         = {1'b0, 1'b1, CMD_INDEX, ADDR, 7'h00, 1'b1};
          cnt_nx        = 8'(FRAME_LEN - 1);
          crc_err_nx    = 1'b0;
          noresp_err_nx = 1'b0;
          stat_err_nx   = 1'b0;
          crc_clr       = 1'b1;
          state_nx      = SEND;
        end
      end

      SEND: begin
        CMD_OE  = 1'b1;
        CMD_OUT = (cnt >= 8'd1 && cnt <= 8'd7) ? crc[crc_idx] : sh[FRAME_LEN-1];
        crc_bit = sh[FRAME_LEN-1];
        crc_en  = (cnt >= 8'd8);
        sh_nx   = {sh[FRAME_LEN-2:0], 1'b1};
        if (cnt == 8'd0) begin
          cnt_nx   = '0;
          state_nx = WAIT_RESP;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end

      WAIT_RESP: begin
        if (!CMD_IN) begin
          // Start bit: restart the CRC with this bit as its first input.
          crc_clr  = 1'b1;
          crc_en   = 1'b1;
          sh_nx    = {sh[FRAME_LEN-2:0], CMD_IN};
          cnt_nx   = 8'(FRAME_LEN - 2);
          state_nx = RECV;
        end else if (cnt == 8'(NCR_MAX - 1)) begin
          noresp_err_nx = 1'b1;
          cnt_nx        = 8'(NCC_CLKS - 1);
          state_nx      = NCC;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      RECV: begin
        sh_nx  = {sh[FRAME_LEN-2:0], CMD_IN};
        crc_en = (cnt >= 8'd8);
        if (cnt == 8'd0) state_nx = CHECK;
        else             cnt_nx   = cnt - 8'd1;
      end

      CHECK: begin
        resp_nx     = sh[R1_ARG_MSB:R1_ARG_LSB];
        crc_err_nx  = bad_frame;
        stat_err_nx = bad_status;
        if (bad_frame || bad_status) begin
          cnt_nx   = 8'(NCC_CLKS - 1);
          state_nx = NCC;
        end else begin
          state_nx = DATA;
        end
      end

      DATA: begin
        RD_ENA = 1'b1;
        if (RD_NORESP) begin
          noresp_err_nx = 1'b1;
          cnt_nx        = 8'(NCC_CLKS - 1);
          state_nx      = NCC;
        end else if (RD_COMPLT) begin
          cnt_nx   = 8'(NCC_CLKS - 1);
          state_nx = NCC;
        end
      end

      NCC: begin
        if (cnt == 8'd0) state_nx = FINISH;
        else             cnt_nx   = cnt - 8'd1;
      end

      FINISH: begin
        DONE     = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_read_cmd.sv
// Directed bench for sd_read_cmd with a card/data-reader model and a
// scoreboard of expected per-transaction results.
module tb_sd_read_cmd;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] ADDR = '0;
  logic        CMD_IN = 1'b1;
  logic        RD_COMPLT = 1'b0;
  logic        RD_NORESP = 1'b0;
  logic        CMD_OUT, CMD_OE, RD_ENA, BUSY, DONE;
  logic        CRCERROR, NORESPERROR, STATUSERROR;
  logic [31:0] RESP;

  sd_read_cmd dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .ADDR        (ADDR),
    .CMD_OUT     (CMD_OUT),
    .CMD_OE      (CMD_OE),
    .CMD_IN      (CMD_IN),
    .RD_ENA      (RD_ENA),
    .RD_COMPLT   (RD_COMPLT),
    .RD_NORESP   (RD_NORESP),
    .RESP        (RESP),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .CRCERROR    (CRCERROR),
    .NORESPERROR (NORESPERROR),
    .STATUSERROR (STATUSERROR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] frame;
    logic [31:0] resp;
    logic        crc_e;
    logic        nr_e;
    logic        st_e;
    int          ena;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_resp = '0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] crc7_of(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [31:0] addr);
    logic [47:0] f;
    f      = {2'b01, 6'd17, addr, 7'h00, 1'b1};
    f[7:1] = crc7_of(f[47:8]);
    return f;
  endfunction

  function automatic logic [47:0] mk_resp(input logic [31:0] status, input logic [5:0] idx,
                                          input logic flip);
    logic [47:0] r;
    r      = {2'b00, idx, status, 7'h00, 1'b1};
    r[7:1] = crc7_of(r[47:8]);
    if (flip) r[1] = ~r[1];
    return r;
  endfunction

  // One full transaction: START, capture the command frame, play the card
  // response (or silence), model the data reader, then score the result.
  task automatic do_txn(input string name, input logic [31:0] addr, input logic reply,
                        input int resp_wait, input logic [31:0] status, input logic [5:0] idx,
                        input logic flip, input int data_wait, input logic both,
                        input logic inject, input int exp_lat, input logic [47:0] exp_frame);
    exp_t        e, got;
    logic [47:0] rsp, frame;
    int          oe_cnt, n, ena_cnt, start_cyc;
    logic        seen_done, pulsed;

    e.frame = exp_frame;
    e.crc_e = reply && (flip || idx != 6'd17);
    e.st_e  = reply && ((status & 32'hFFF80000) != 32'h0);
    e.ena   = (reply && !e.crc_e && !e.st_e) ? data_wait + 1 : 0;
    e.nr_e  = !reply || (both && e.ena > 0);
    e.resp  = reply ? status : last_resp;
    e.lat   = exp_lat;
    sb.push_back(e);
    if (reply) last_resp = status;

    @(negedge CLK);
    START = 1'b1;
    ADDR  = addr;
    @(negedge CLK);
    START     = 1'b0;
    start_cyc = cyc;

    frame  = '0;
    oe_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      START = inject && (i == 10);
      if (CMD_OE) begin
        frame = {frame[46:0], CMD_OUT};
        oe_cnt++;
      end else if (oe_cnt > 0) begin
        break;
      end
      @(negedge CLK);
    end
    START = 1'b0;
    check({name, ":frame"}, 64'(frame), 64'(sb[0].frame));
    check({name, ":oe_cycles"}, 64'(oe_cnt), 64'd48);
    check({name, ":idle_cmd_out"}, 64'(CMD_OUT), 64'd1);

    if (reply) begin
      rsp = mk_resp(status, idx, flip);
      repeat (resp_wait) @(negedge CLK);
      for (int b = 47; b >= 0; b--) begin
        CMD_IN = rsp[b];
        @(negedge CLK);
      end
      CMD_IN = 1'b1;
    end else begin
      n = 0;
      while (!NORESPERROR && n < 200) begin
        n++;
        @(negedge CLK);
      end
      check({name, ":ncr_wait"}, 64'(n), 64'd64);
    end

    ena_cnt   = 0;
    seen_done = 1'b0;
    pulsed    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      START = 1'b0;
      if (DONE) begin
        seen_done = 1'b1;
        break;
      end
      if (RD_ENA) ena_cnt++;
      RD_COMPLT = RD_ENA && (ena_cnt == data_wait + 1);
      RD_NORESP = RD_COMPLT && both;
      if (inject && !pulsed && ena_cnt > 0 && !RD_ENA) begin
        START  = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge CLK);
    end
    START     = 1'b0;
    RD_COMPLT = 1'b0;
    RD_NORESP = 1'b0;

    got = sb.pop_front();
    check({name, ":done_seen"}, 64'(seen_done), 64'd1);
    check({name, ":busy_in_finish"}, 64'(BUSY), 64'd1);
    check({name, ":resp"}, 64'(RESP), 64'(got.resp));
    check({name, ":crcerror"}, 64'(CRCERROR), 64'(got.crc_e));
    check({name, ":noresperror"}, 64'(NORESPERROR), 64'(got.nr_e));
    check({name, ":statuserror"}, 64'(STATUSERROR), 64'(got.st_e));
    check({name, ":rd_ena_cycles"}, 64'(ena_cnt), 64'(got.ena));
    if (got.lat >= 0) check({name, ":latency"}, 64'(cyc - start_cyc + 1), 64'(got.lat));

    @(negedge CLK);
    check({name, ":done_one_cycle"}, 64'(DONE), 64'd0);
    check({name, ":busy_cleared"}, 64'(BUSY), 64'd0);
    @(negedge CLK);
    check({name, ":stays_idle"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    int dones;

    repeat (3) @(negedge CLK);
    check("reset:cmd_out", 64'(CMD_OUT), 64'd1);
    check("reset:cmd_oe", 64'(CMD_OE), 64'd0);
    check("reset:rd_ena", 64'(RD_ENA), 64'd0);
    check("reset:resp", 64'(RESP), 64'd0);
    check("reset:busy", 64'(BUSY), 64'd0);
    check("reset:done", 64'(DONE), 64'd0);
    check("reset:flags", 64'({CRCERROR, NORESPERROR, STATUSERROR}), 64'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    do_txn("t1_nominal", 32'h0, 1'b1, 5, 32'h00000900, 6'd17, 1'b0, 20, 1'b0, 1'b0, -1,
           48'h510000000055);
    do_txn("t2_no_resp", 32'h00000400, 1'b0, 0, 32'h0, 6'd17, 1'b0, 0, 1'b0, 1'b0, -1,
           mk_frame(32'h00000400));
    do_txn("t3_bad_crc", 32'h12345678, 1'b1, 2, 32'h00000900, 6'd17, 1'b1, 0, 1'b0, 1'b0, -1,
           mk_frame(32'h12345678));
    do_txn("t4_bad_index", 32'hDEADBEEF, 1'b1, 3, 32'h00000900, 6'd16, 1'b0, 0, 1'b0, 1'b0, -1,
           mk_frame(32'hDEADBEEF));
    do_txn("t5_out_of_range", 32'h00000010, 1'b1, 1, 32'h80000900, 6'd17, 1'b0, 0, 1'b0, 1'b0, -1,
           mk_frame(32'h00000010));
    do_txn("t6_both_inject", 32'hA5A50001, 1'b1, 0, 32'h00000500, 6'd17, 1'b0, 3, 1'b1, 1'b1, -1,
           mk_frame(32'hA5A50001));
    do_txn("t7_min_latency", 32'hFFFFFFFF, 1'b1, 0, 32'h00000900, 6'd17, 1'b0, 0, 1'b0, 1'b0, 107,
           mk_frame(32'hFFFFFFFF));

    // Abort mid-frame with an asynchronous reset pulse.
    @(negedge CLK);
    START = 1'b1;
    ADDR  = 32'h00000055;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    check("t8_abort:in_send", 64'(CMD_OE), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("t8_abort:cmd_oe", 64'(CMD_OE), 64'd0);
    check("t8_abort:busy", 64'(BUSY), 64'd0);
    check("t8_abort:cmd_out", 64'(CMD_OUT), 64'd1);
    @(negedge CLK);
    RST       = 1'b0;
    last_resp = 32'h0;
    dones     = 0;
    for (int i = 0; i < 60; i++) begin
      if (DONE) dones++;
      @(negedge CLK);
    end
    check("t8_abort:no_done", 64'(dones), 64'd0);

    do_txn("t9_after_abort", 32'h00000055, 1'b1, 4, 32'h00000900, 6'd17, 1'b0, 2, 1'b0, 1'b0, -1,
           mk_frame(32'h00000055));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_read_cmd.md
Name: sd_read_cmd

Overview:
- Upstream controller for the 4-bit SD data reader.
- On a START request it serialises a CMD17 (READ_SINGLE_BLOCK) frame on the SD CMD line and receives and checks the 48-bit R1 response.
- It then holds the data reader's enable until the reader reports completion or no-response, and reports one consolidated result to the host sequencer.

Parameters:
- CMD_INDEX, 17, command index placed in frame bits [45:40] and expected in the response echo.
- NCR_MAX, 64, max CMD-idle clocks tolerated between command end and response start bit.
- NCC_CLKS, 8, idle clocks enforced after completion before the next START is accepted.
- STATUS_ERR_MASK, 32'hFFF80000, R1 card-status bits treated as errors.

Ports:
- CLK  in  1  SD clock domain clock; all logic on posedge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle request; sampled only in IDLE.
- ADDR  in  32  block address (argument), latched on accepted START.
- CMD_OUT  out  1  serial command bit to pad.
- CMD_OE  out  1  pad output enable; 1 only while transmitting.
- CMD_IN  in  1  sampled CMD pad (already synchronised).
- RD_ENA  out  1  enable to the data reader.
- RD_COMPLT  in  1  data reader block complete.
- RD_NORESP  in  1  data reader no-response error.
- RESP  out  32  card status from the last R1 response.
- BUSY  out  1  high from accepted START until back in IDLE.
- DONE  out  1  one-cycle pulse at end of every transaction, success or error.
- CRCERROR  out  1  response CRC/frame/index mismatch.
- NORESPERROR  out  1  command or data no-response.
- STATUSERROR  out  1  (RESP & STATUS_ERR_MASK) != 0.

Behaviour:
- Reset values:
  - Outputs: CMD_OUT=1, CMD_OE=0, RD_ENA=0, RESP=0, BUSY=0, DONE=0, all error flags 0.
  - Internal: state=IDLE, counters=0, CRC=0.
- Reset asserted mid-transaction aborts immediately: CMD_OE drops asynchronously, and no DONE pulse is produced.
- Frame is 48 bits, MSB first:
  - bit 47 = 0 (start), bit 46 = 1 (transmitter), [45:40] = CMD_INDEX, [39:8] = ADDR, [7:1] = CRC7, bit 0 = 1 (end).
- CRC7:
  - Polynomial x^7+x^3+1, register init 0.
  - Fed serially with frame bits 47..8; CRC emitted MSB first.
- States: IDLE, SEND, WAIT_RESP, RECV, CHECK, DATA, NCC, FINISH.
- IDLE:
  - START=1 latches ADDR, clears all error flags, sets BUSY, and moves to SEND.
  - START while BUSY is ignored.
- SEND:
  - Bit counter runs 47..0. Bit 47 appears on CMD_OUT the cycle after START, with CMD_OE=1 for exactly 48 cycles.
  - After bit 0: CMD_OE=0, CMD_OUT=1, go to WAIT_RESP.
- WAIT_RESP:
  - Each cycle CMD_IN=1 increments the wait counter.
  - CMD_IN=0 captures response bit 47 and moves to RECV.
  - If the counter reaches NCR_MAX with no start bit: NORESPERROR=1, go to NCC.
- RECV:
  - Shifts 47 more bits into a 48-bit register, with CRC7 run over response bits 47..8.
  - Go to CHECK after bit 0.
- CHECK (1 cycle):
  - RESP <= response[39:8].
  - CRCERROR=1 if bit46!=0, or [45:40]!=CMD_INDEX, or [7:1]!=computed CRC, or bit0!=1.
  - STATUSERROR=1 if masked status is non-zero.
  - Any error: go to NCC. Otherwise go to DATA.
- DATA:
  - RD_ENA=1. RD_COMPLT=1 goes to NCC.
  - RD_NORESP=1 sets NORESPERROR and goes to NCC.
  - If both are high in the same cycle, RD_NORESP wins.
  - RD_ENA drops on the cycle the state leaves DATA.
- NCC:
  - CMD_OE=0, CMD_OUT=1, RD_ENA=0 for NCC_CLKS cycles, then FINISH.
- FINISH:
  - DONE=1 for one cycle, BUSY=0 next cycle, return to IDLE.
- Error flags and RESP hold until the next accepted START.
- Latency:
  - START to first response sample is at least 49 cycles.
  - Minimum total with a zero-wait response and immediate RD_COMPLT is 48+1+47+1+1+NCC_CLKS+1 cycles.

Decomposition:
- Package sd_pkg:
  - state enum.
  - Frame length 48.
  - R1 field bit positions.
  - CRC7 polynomial 7'h09.
  - Default STATUS_ERR_MASK.
  - CMD17 index constant.
- Sub-module sd_crc7:
  - Serial CRC7 with CLR, EN, BIT_IN, CRC[6:0].
  - One instance, time-shared between TX and RX, cleared on START and on response start bit.

Test Plan:
- START, ADDR=0: CMD_OUT frame = 48'h510000000055 (CRC7=7'h2A), CMD_OE high exactly 48 cycles. Card model replies R1 status 32'h00000900 with valid CRC after 5 idle cycles, then RD_COMPLT after 20 cycles: RESP=32'h00000900, no errors, RD_ENA high 21 cycles, one DONE pulse.
- CMD_IN held 1 after the frame: NORESPERROR=1 after exactly 64 wait cycles. RD_ENA never asserted; DONE after NCC.
- Response with flipped CRC bit: CRCERROR=1, RD_ENA stays 0. Same check repeated with echoed index 6'd16, also giving CRCERROR=1.
- R1 status 32'h80000900 (OUT_OF_RANGE): STATUSERROR=1, RESP=32'h80000900, no data phase.
- Data phase with RD_NORESP and RD_COMPLT high in the same cycle: NORESPERROR=1, RD_ENA drops next cycle. START pulsed during SEND and NCC is ignored.
- RST pulsed mid-SEND: CMD_OE=0 and BUSY=0 immediately, no DONE. A new START then produces a fresh correct frame.
